ram_dp_sync: RTL

Parametrised synchronous single-array main memory with two requester ports: CPU and DMA/data-break. One access per clock, chosen by a built-in arbiter. Each access gets a one-cycle acknowledge with registered read data. Replaces the asynchronous 32Kx12 core model so memory timing is clocked and FPGA block-RAM mappable; default parameters give the PDP-8 32K x 12-bit field space.

---
 rtl/ram_dp_sync_if.sv | 21 ++
 rtl/ram_dp_sync.sv | 131 +++++++++++++
 2 files changed

// File: rtl/ram_dp_sync_if.sv
// Requester bus for one port of ram_dp_sync.
//   req   : access request, level, held until ack
//   we    : 1 = write, 0 = read
//   addr  : word address
//   wdata : write data
//   ack   : one-cycle completion pulse
//   rdata : read data (write-through data on writes), held between acks
interface ram_dp_sync_if #(
  parameter int unsigned DW = 12,
  parameter int unsigned AW = 15
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_dp_sync.sv
// Synchronous single-array main memory shared by a CPU port and a DMA port.
// One access per clock, chosen by a built-in arbiter; every access gets a
// one-cycle ack with registered read data.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   cpu, dma     : ram_dp_sync_if.slave requester buses
//   par_inj      : invert stored parity on the write being granted
//   par_err      : parity mismatch pulse, with the ack of the faulting read
//   busy         : high in any cycle an ack is delivered
// Optional feature: define RAM_PARITY_EN to store an even-parity bit per word.
module ram_dp_sync #(
  parameter int unsigned DW       = 12,
  parameter int unsigned AW       = 15,
  parameter int unsigned DEPTH    = 32768,
  parameter int unsigned DMA_PRIO = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  ram_dp_sync_if.slave  cpu,
  ram_dp_sync_if.slave  dma,
  input  logic          par_inj,
  output logic          par_err,
  output logic          busy
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef RAM_PARITY_EN
  localparam int unsigned MW = DW + 1;
`else
  localparam int unsigned MW = DW;
`endif
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [MW-1:0] mem [DEPTH];

  logic          cpu_ack_q, dma_ack_q, busy_q, last_dma_q;
  logic [DW-1:0] cpu_rdata_q, dma_rdata_q;
  logic          cpu_elig_c, dma_elig_c, gnt_cpu_c, gnt_dma_c, gnt_any_c;
  logic          sel_we_c, in_range_c;
  logic [AW-1:0] sel_addr_c;
  logic [DW-1:0] sel_wdata_c, acc_data_c;
  logic [IW-1:0] sel_idx_c;
  logic [MW-1:0] rd_word_c, wr_word_c;

  // Arbiter: a port in its ack cycle is ineligible, which bounds CPU wait
  // to one cycle even under fixed DMA priority.
  always_comb begin
    cpu_elig_c = cpu.req & ~cpu_ack_q;
    dma_elig_c = dma.req & ~dma_ack_q;
    gnt_cpu_c  = 1'b0;
    gnt_dma_c  = 1'b0;
    if (cpu_elig_c && dma_elig_c) begin
      if (DMA_PRIO != 0 || !last_dma_q) gnt_dma_c = 1'b1;
      else                              gnt_cpu_c = 1'b1;
    end else begin
      gnt_cpu_c = cpu_elig_c;
      gnt_dma_c = dma_elig_c;
    end
    gnt_any_c = gnt_cpu_c | gnt_dma_c;
  end

  // Single shared access path: select the granted port's request.
  always_comb begin
    sel_we_c    = gnt_dma_c ? dma.we    : cpu.we;
    sel_addr_c  = gnt_dma_c ? dma.addr  : cpu.addr;
    sel_wdata_c = gnt_dma_c ? dma.wdata : cpu.wdata;
    in_range_c  = {1'b0, sel_addr_c} < DEPTH_W;
    sel_idx_c   = sel_addr_c[IW-1:0];
    rd_word_c   = mem[sel_idx_c];
`ifdef RAM_PARITY_EN
    wr_word_c   = {(^sel_wdata_c) ^ par_inj, sel_wdata_c};
`else
    wr_word_c   = sel_wdata_c;
`endif
    if (sel_we_c)        acc_data_c = sel_wdata_c;
    else if (in_range_c) acc_data_c = rd_word_c[DW-1:0];
    else                 acc_data_c = '0;
  end

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (gnt_any_c && sel_we_c && in_range_c) mem[sel_idx_c] <= wr_word_c;
  end

  // Ack, read data and round-robin pointer; reset discards a pending ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      last_dma_q  <= 1'b1;
    end else begin
      cpu_ack_q <= gnt_cpu_c;
      dma_ack_q <= gnt_dma_c;
      busy_q    <= gnt_any_c;
      if (gnt_cpu_c) begin
        cpu_rdata_q <= acc_data_c;
        last_dma_q  <= 1'b0;
      end
      if (gnt_dma_c) begin
        dma_rdata_q <= acc_data_c;
        last_dma_q  <= 1'b1;
      end
    end
  end

`ifdef RAM_PARITY_EN
  logic par_err_q;

  // Even parity over data+parity bit is zero for a clean word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) par_err_q <= 1'b0;
    else          par_err_q <= gnt_any_c & ~sel_we_c & in_range_c & (^rd_word_c);
  end

  assign par_err = par_err_q;
`else
  wire unused_par_inj = par_inj;

  assign par_err = 1'b0;
`endif

  assign cpu.ack   = cpu_ack_q;
  assign cpu.rdata = cpu_rdata_q;
  assign dma.ack   = dma_ack_q;
  assign dma.rdata = dma_rdata_q;
  assign busy      = busy_q;

endmodule
